// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned INST_BUS = 16;
  localparam int unsigned PC_BUS   = 16;

  // NOP encoding injected into IF/ID on squash and after reset
  localparam logic [INST_BUS-1:0] NOP_ENC = 16'h0800;

  // Fetch FSM states
  typedef enum logic [0:0] {
    IF_ST_FETCH = 1'b0,
    IF_ST_HOLD  = 1'b1
  } if_state_e;

  // Instruction word paired with its fetch address
  typedef struct packed {
    logic [INST_BUS-1:0] inst;
    logic [PC_BUS-1:0]   pc;
  } ifid_t;

  // Sequential word address; wraps 16'hFFFF -> 16'h0000
  function automatic logic [PC_BUS-1:0] pc_next_seq(input logic [PC_BUS-1:0] pc);
    return pc + PC_BUS'(1);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and IMEM.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                im_req;
  logic [PC_BUS-1:0]   im_addr;
  logic [INST_BUS-1:0] im_rdata;
  logic                im_ready;

  // Fetch stage drives the request side
  modport master (
    output im_req,
    output im_addr,
    input  im_rdata,
    input  im_ready
  );

  // Instruction memory answers
  modport slave (
    input  im_req,
    input  im_addr,
    output im_rdata,
    output im_ready
  );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC selection: reset value, redirect target,
// sequential increment, or hold.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [PC_BUS-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [PC_BUS-1:0] target,
  input  logic              inc,
  output logic [PC_BUS-1:0] pc
);

  // Redirect beats increment; otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc_next_seq(pc);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the im_* handshake and
// holds the IF/ID register feeding the decoder. Absorbs downstream stalls,
// shared-SRAM conflicts (mem_busy) and redirects (jump_en).
//
// Build option: define IF_DELAY_SLOT_EN to keep the instruction after a
// branch (returning word, hold buffer or IF/ID) as an architectural delay
// slot. Without it a redirect squashes IF/ID to NOP and drops buffered work.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_BUS-1:0]   RESET_PC = 16'h0000,
  parameter logic [INST_BUS-1:0] NOP_INST = NOP_ENC
) (
  input  logic                clk_50MHz,
  input  logic                rst,
  input  logic                stall,
  input  logic                jump_en,
  input  logic [PC_BUS-1:0]   jump_target,
  input  logic                mem_busy,
  if_stage_if.master          im,
  output logic [INST_BUS-1:0] inst,
  output logic [PC_BUS-1:0]   pc_out,
  output logic                valid
);

`ifdef IF_DELAY_SLOT_EN
  localparam logic SQUASH_ON_JUMP = 1'b0;
`else
  localparam logic SQUASH_ON_JUMP = 1'b1;
`endif

  if_state_e         state;
  ifid_t             hold_q;
  logic              req_en;
  logic              in_flight;
  logic              fire;
  logic [PC_BUS-1:0] pc;

  // mem_busy gates only new requests; an outstanding one keeps asking.
  // req_en keeps the request low until the first edge after reset release.
  assign im.im_req  = req_en && (state == IF_ST_FETCH) && (!mem_busy || in_flight);
  assign im.im_addr = pc;
  assign fire       = im.im_req && im.im_ready;

  if_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk_50MHz),
    .rst    (rst),
    .load   (jump_en),
    .target (jump_target),
    .inc    (fire),
    .pc     (pc)
  );

  // Fetch FSM, hold buffer and IF/ID register
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state     <= IF_ST_FETCH;
      hold_q    <= '0;
      req_en    <= 1'b0;
      in_flight <= 1'b0;
      inst      <= NOP_INST;
      pc_out    <= '0;
      valid     <= 1'b0;
    end else begin
      req_en    <= 1'b1;
      in_flight <= im.im_req && !im.im_ready && !jump_en;
      if (jump_en && SQUASH_ON_JUMP) begin
        state  <= IF_ST_FETCH;
        hold_q <= '0;
        inst   <= NOP_INST;
        valid  <= 1'b0;
      end else begin
        case (state)
          IF_ST_FETCH: begin
            if (fire && !stall) begin
              inst   <= im.im_rdata;
              pc_out <= pc;
              valid  <= 1'b1;
            end else if (fire) begin
              hold_q <= '{inst: im.im_rdata, pc: pc};
              state  <= IF_ST_HOLD;
            end else if (!stall) begin
              inst  <= NOP_INST;
              valid <= 1'b0;
            end
          end
          IF_ST_HOLD: begin
            if (!stall) begin
              inst   <= hold_q.inst;
              pc_out <= hold_q.pc;
              valid  <= 1'b1;
              state  <= IF_ST_FETCH;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized
// run against an in-order instruction-stream reference model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_target = 16'h0000;
  logic        mem_busy = 1'b0;
  logic [15:0] inst;
  logic [15:0] pc_out;
  logic        valid;

  int unsigned wait_n = 0;
  int unsigned wcnt;
  int          checks = 0;
  int          failures = 0;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (16'h0000),
    .NOP_INST (16'h0800)
  ) dut (
    .clk_50MHz   (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .mem_busy    (mem_busy),
    .im          (bus),
    .inst        (inst),
    .pc_out      (pc_out),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  // Instruction memory contents
  function automatic logic [15:0] word_at(input logic [15:0] a);
    case (a)
      16'h0000: word_at = 16'h4801;
      16'h0001: word_at = 16'h4802;
      16'h0002: word_at = 16'h4803;
      16'h0003: word_at = 16'h0800;
      default:  word_at = (a * 16'h9E37) ^ 16'h3C5A;
    endcase
  endfunction

  // Memory with wait_n wait states per request
  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (bus.im_req && !bus.im_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign bus.im_ready = bus.im_req && (wcnt >= wait_n);
  assign bus.im_rdata = word_at(bus.im_addr);

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (inst !== 16'h0800) begin failures++; $display("FAIL reset_inst got=%h exp=0800", inst); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (pc_out !== 16'h0000) begin failures++; $display("FAIL reset_pc_out got=%h exp=0000", pc_out); end
    checks++; if (bus.im_req !== 1'b0) begin failures++; $display("FAIL reset_im_req got=%b exp=0", bus.im_req); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.im_req !== 1'b0) begin failures++; $display("FAIL release_no_req got=%b exp=0", bus.im_req); end
    tick;
    checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 16'h0000) begin
      failures++; $display("FAIL first_req got=%b/%h exp=1/0000", bus.im_req, bus.im_addr); end
  endtask

  task test_zero_wait;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (inst !== word_at(16'(k)) || pc_out !== 16'(k) || valid !== 1'b1) begin
        failures++; $display("FAIL zero_wait[%0d] got=%h/%h/%b exp=%h/%h/1", k, inst, pc_out, valid, word_at(16'(k)), 16'(k)); end
    end
  endtask

  task test_stall;
    tick;
    checks++; if (bus.im_addr !== 16'd5) begin failures++; $display("FAIL stall_pre_addr got=%h exp=0005", bus.im_addr); end
    stall = 1'b1;
    tick;
    checks++; if (bus.im_req !== 1'b0 || inst !== word_at(16'd4)) begin
      failures++; $display("FAIL stall_hold got=%b/%h exp=0/%h", bus.im_req, inst, word_at(16'd4)); end
    tick;
    tick;
    stall = 1'b0;
    tick;
    checks++; if (inst !== word_at(16'd5) || pc_out !== 16'd5 || valid !== 1'b1) begin
      failures++; $display("FAIL stall_release got=%h/%h/%b exp=%h/0005/1", inst, pc_out, valid, word_at(16'd5)); end
    checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 16'd6) begin
      failures++; $display("FAIL stall_next_addr got=%b/%h exp=1/0006", bus.im_req, bus.im_addr); end
    tick;
    checks++; if (inst !== word_at(16'd6) || pc_out !== 16'd6) begin
      failures++; $display("FAIL stall_after got=%h/%h exp=%h/0006", inst, pc_out, word_at(16'd6)); end
  endtask

  task test_mem_busy;
    tick;
    mem_busy = 1'b1;
    #1;
    checks++; if (bus.im_req !== 1'b0) begin failures++; $display("FAIL busy_gate1 got=%b exp=0", bus.im_req); end
    tick;
    checks++; if (bus.im_req !== 1'b0 || valid !== 1'b0) begin
      failures++; $display("FAIL busy_gate2 got=%b/%b exp=0/0", bus.im_req, valid); end
    tick;
    mem_busy = 1'b0;
    #1;
    checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 16'd8) begin
      failures++; $display("FAIL busy_retry got=%b/%h exp=1/0008", bus.im_req, bus.im_addr); end
    for (int k = 8; k < 10; k++) begin
      tick;
      checks++; if (inst !== word_at(16'(k)) || pc_out !== 16'(k) || valid !== 1'b1) begin
        failures++; $display("FAIL busy_seq[%0d] got=%h/%h/%b exp=%h/%h/1", k, inst, pc_out, valid, word_at(16'(k)), 16'(k)); end
    end
  endtask

  task test_jump;
    checks++; if (bus.im_addr !== 16'd10 || bus.im_ready !== 1'b1) begin
      failures++; $display("FAIL jump_pre got=%h/%b exp=000a/1", bus.im_addr, bus.im_ready); end
    jump_en = 1'b1;
    jump_target = 16'h0040;
    tick;
    jump_en = 1'b0;
`ifdef IF_DELAY_SLOT_EN
    checks++; if (inst !== word_at(16'd10) || pc_out !== 16'd10 || valid !== 1'b1) begin
      failures++; $display("FAIL jump_slot got=%h/%h/%b exp=%h/000a/1", inst, pc_out, valid, word_at(16'd10)); end
`else
    checks++; if (inst !== 16'h0800 || valid !== 1'b0) begin
      failures++; $display("FAIL jump_squash got=%h/%b exp=0800/0", inst, valid); end
`endif
    checks++; if (bus.im_addr !== 16'h0040) begin failures++; $display("FAIL jump_addr got=%h exp=0040", bus.im_addr); end
    tick;
    checks++; if (inst !== word_at(16'h0040) || pc_out !== 16'h0040 || valid !== 1'b1) begin
      failures++; $display("FAIL jump_target_inst got=%h/%h/%b exp=%h/0040/1", inst, pc_out, valid, word_at(16'h0040)); end
  endtask

  task test_jump_stall;
    stall = 1'b1;
    jump_en = 1'b1;
    jump_target = 16'h0040;
    tick;
    jump_en = 1'b0;
    stall = 1'b0;
    checks++; if (bus.im_addr !== 16'h0040) begin failures++; $display("FAIL jump_stall_addr got=%h exp=0040", bus.im_addr); end
`ifndef IF_DELAY_SLOT_EN
    checks++; if (bus.im_req !== 1'b1) begin failures++; $display("FAIL jump_stall_req got=%b exp=1", bus.im_req); end
`endif
    tick;
`ifndef IF_DELAY_SLOT_EN
    checks++; if (inst !== word_at(16'h0040) || pc_out !== 16'h0040) begin
      failures++; $display("FAIL jump_stall_inst got=%h/%h exp=%h/0040", inst, pc_out, word_at(16'h0040)); end
`endif
    tick;
  endtask

  task test_wrap;
    jump_en = 1'b1;
    jump_target = 16'hFFFF;
    tick;
    jump_en = 1'b0;
    checks++; if (bus.im_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_addr got=%h exp=ffff", bus.im_addr); end
    tick;
    checks++; if (inst !== word_at(16'hFFFF) || pc_out !== 16'hFFFF || bus.im_addr !== 16'h0000) begin
      failures++; $display("FAIL wrap_next got=%h/%h/%h exp=%h/ffff/0000", inst, pc_out, bus.im_addr, word_at(16'hFFFF)); end
  endtask

  task test_wait;
    wait_n = 2;
    tick;
    checks++; if (valid !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== 16'h0000) begin
      failures++; $display("FAIL wait_bubble got=%b/%b/%h exp=0/1/0000", valid, bus.im_req, bus.im_addr); end
    mem_busy = 1'b1;
    #1;
    checks++; if (bus.im_req !== 1'b1) begin failures++; $display("FAIL wait_inflight_req got=%b exp=1", bus.im_req); end
    tick;
    checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 16'h0000) begin
      failures++; $display("FAIL wait_stable got=%b/%h exp=1/0000", bus.im_req, bus.im_addr); end
    tick;
    checks++; if (inst !== word_at(16'h0000) || pc_out !== 16'h0000 || valid !== 1'b1) begin
      failures++; $display("FAIL wait_done got=%h/%h/%b exp=%h/0000/1", inst, pc_out, valid, word_at(16'h0000)); end
    mem_busy = 1'b0;
    wait_n = 0;
    #1;
  endtask

  task test_reset_hold;
    stall = 1'b1;
    tick;
    checks++; if (bus.im_req !== 1'b0) begin failures++; $display("FAIL rh_in_hold got=%b exp=0", bus.im_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (inst !== 16'h0800 || valid !== 1'b0 || pc_out !== 16'h0000 || bus.im_req !== 1'b0) begin
      failures++; $display("FAIL rh_clear got=%h/%b/%h/%b exp=0800/0/0000/0", inst, valid, pc_out, bus.im_req); end
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick;
    checks++; if (bus.im_req !== 1'b1 || bus.im_addr !== 16'h0000) begin
      failures++; $display("FAIL rh_restart got=%b/%h exp=1/0000", bus.im_req, bus.im_addr); end
    tick;
    checks++; if (inst !== word_at(16'h0000) || pc_out !== 16'h0000 || valid !== 1'b1) begin
      failures++; $display("FAIL rh_first got=%h/%h/%b exp=%h/0000/1", inst, pc_out, valid, word_at(16'h0000)); end
  endtask

  // Reference: the consumed stream is mem[exp_pc], exp_pc, exp_pc+1, ...,
  // restarting at jump_target after every redirect.
  task test_random;
    logic [15:0] exp_pc;
    int          consumed;
    consumed = 0;
    stall = 1'b0;
    mem_busy = 1'b0;
    wait_n = 0;
    jump_en = 1'b1;
    jump_target = 16'h0100;
    exp_pc = 16'h0100;
    tick;
    jump_en = 1'b0;
    tick;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 63) == 0) wait_n = $urandom_range(0, 2);
`ifndef IF_DELAY_SLOT_EN
      jump_en = ($urandom_range(0, 29) == 0);
      jump_target = 16'($urandom);
`endif
      #1;
      if (valid === 1'b1 && !stall) begin
        checks++;
        if (pc_out !== exp_pc || inst !== word_at(exp_pc)) begin
          failures++;
          $display("FAIL rand_stream[%0d] got=%h/%h exp=%h/%h", i, inst, pc_out, word_at(exp_pc), exp_pc);
          exp_pc = pc_out;
        end
        consumed++;
        exp_pc = exp_pc + 16'd1;
      end
      if (jump_en) exp_pc = jump_target;
      tick;
    end
    stall = 1'b0;
    mem_busy = 1'b0;
    jump_en = 1'b0;
    wait_n = 0;
    checks++; if (consumed < 300) begin failures++; $display("FAIL rand_progress got=%0d exp>=300", consumed); end
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_stall;
    test_mem_busy;
    test_jump;
    test_jump_stall;
    test_wrap;
    test_wait;
    test_reset_hold;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the 16-bit MIPS16-subset CPU. It sits directly upstream of the instruction decoder: it owns the PC, fetches from instruction memory through a request/ready handshake, and holds the IF/ID pipeline register whose `inst` output feeds the decoder. It absorbs downstream stalls, shared-SRAM conflicts and branch/jump redirects.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP_INST`, default 16'h0800: encoding of the NOP instruction, injected on squash.
- `clk_50MHz`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hazard hold from downstream; freeze PC and IF/ID.
- `jump_en`  in  1: redirect request from the branch/jump resolution logic.
- `jump_target`  in  16: absolute word address of the redirect target.
- `mem_busy`  in  1: data-side access owns the shared SRAM this cycle.
- `im_req`  out  1: instruction-memory read request.
- `im_addr`  out  16: instruction-memory word address.
- `im_rdata`  in  16: instruction word; valid when `im_ready`=1.
- `im_ready`  in  1: read completes this cycle.
- `inst`  out  16: IF/ID instruction to the decoder.
- `pc_out`  out  16: IF/ID address of `inst`, used by MFPC and PC-relative branches.
- `valid`  out  1: `inst` is a real fetched instruction, not an injected NOP.

## Operation
- Addressing is by word; sequential PC = PC+1, with 16-bit wrap (16'hFFFF → 16'h0000).
- FSM states:
  - **FETCH**
    - `im_req` = !`mem_busy`; `im_addr` = PC.
    - On `im_req` && `im_ready` && !`stall`: IF/ID ← {`im_rdata`, PC, valid=1}; PC ← PC+1. Stay in FETCH.
    - On `im_req` && `im_ready` && `stall`: hold buffer ← {`im_rdata`, PC}; PC ← PC+1; go to HOLD.
    - `mem_busy` with no request in flight: no request is issued; retry next cycle.
  - **HOLD**
    - `im_req`=0.
    - When `stall` drops: IF/ID ← hold buffer, valid=1; go to FETCH.
- `stall`=1 in any state: IF/ID is unchanged.
- Redirect (`jump_en`=1) has priority over everything, including `stall` and `mem_busy`.
  - PC ← `jump_target`; FSM → FETCH.
  - Squash handling is set by the macro below.
  - `im_rdata` returning in the redirect cycle is dropped unless it is kept as the delay slot.
- The data SRAM has priority: `mem_busy` only gates new requests. A request already accepted (`im_ready`) completes normally.

## Timing
- Reset (asynchronous assert, release on a clock edge):
  - PC=`RESET_PC`, `inst`=`NOP_INST`, `pc_out`=0, `valid`=0, `im_req`=0.
  - Hold buffer empty; FSM=FETCH.
  - First `im_req`=1 occurs on the first cycle after release.
- Zero-wait memory (`im_ready` asserted with `im_req`): one instruction per cycle; `inst` is valid on the clock edge after the request.
- N-wait memory: `im_req` and `im_addr` stay stable until `im_ready`. Meanwhile `inst` keeps its previous value, or becomes `NOP_INST`/valid=0 if the downstream consumed it without `stall`.
- Redirect: `im_addr`=`jump_target` on the cycle after `jump_en`. Redirect penalty is 1 cycle.
- Reset asserted mid-HOLD or mid-wait: all state clears immediately and the buffered instruction is lost.

## Configuration
- `IF_DELAY_SLOT_EN` defined:
  - The instruction sequentially after a branch is the architectural delay slot.
  - On `jump_en`, an instruction in IF/ID, in the hold buffer, or returning this cycle is kept and delivered once, then fetching continues at the target.
- Undefined:
  - On `jump_en`, IF/ID ← {`NOP_INST`, valid=0}; the hold buffer and any returning word are discarded.

## Structure
- Shared package/define file holds:
  - `INST_BUS`/`PC_BUS` widths;
  - the NOP encoding constant;
  - FSM state encodings `IF_ST_FETCH`/`IF_ST_HOLD`.
- One natural sub-module, `pc_reg`: PC register with next-PC mux (reset, +1, target, hold).

## Test plan
- Reset release, zero-wait memory at addresses 0..3 = 16'h4801/4802/4803/0800 → `inst` sequence 4801, 4802, 4803, 0800 on consecutive cycles; `pc_out` 0,1,2,3.
- `stall` for 3 cycles while `im_ready`=1 at PC=5 → FSM enters HOLD, `im_req`=0; after release `inst` = word@5 with `pc_out`=5, and the next fetch is address 6.
- `mem_busy`=1 for 2 cycles at PC=8 → `im_req`=0 for those 2 cycles, then `im_addr`=8; no address is skipped or duplicated.
- `jump_en` with `jump_target`=16'h0040 while word@10 is returning:
  - with `IF_DELAY_SLOT_EN`: `inst`=word@10, then word@0x40;
  - without: `inst`=`NOP_INST` with `valid`=0, then word@0x40.
- `jump_en` and `stall` simultaneously → `im_addr`=0x40 on the next cycle; the redirect is not blocked.
- PC=16'hFFFF fetched → next `im_addr`=16'h0000; reset asserted during HOLD → `inst`=16'h0800, `valid`=0 immediately.
